// File: rtl/my_project_pkg.sv
// Shared sizes, state encoding and result saturation for the
// Gaussian-spot moment estimator.
package my_project_pkg;

   localparam int DATA_W = 16;
   localparam int ROWS   = 48;
   localparam int COLS   = 48;
   localparam int NPIX   = ROWS * COLS;
   localparam int XY_W   = 6;
   localparam int S_W    = 27;
   localparam int M1_W   = 33;
   localparam int M2_W   = 39;
   localparam int NRES   = 5;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CALC,
      OUT
   } state_t;

   function automatic logic [DATA_W-1:0] sat_u(input logic [M2_W-1:0] v);
      if (v > M2_W'(32767))
         return 16'h7FFF;
      else
         return v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/my_project_div.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The quotient register doubles as the dividend shift register.
module my_project_div
   import my_project_pkg::*;
(
   input  logic            ap_clk,
   input  logic            ap_rst,
   input  logic            start,
   input  logic [M2_W-1:0] dividend,
   input  logic [S_W-1:0]  divisor,
   output logic            busy,
   output logic            done,
   output logic [M2_W-1:0] quotient
);

   logic [S_W-1:0] rem;
   logic [S_W-1:0] den;
   logic [5:0]     cnt;
   logic [S_W:0]   trial;
   logic           take;

   assign trial = {rem, quotient[M2_W-1]};
   assign take  = trial >= {1'b0, den};

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         rem      <= '0;
         den      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         quotient <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            rem      <= '0;
            den      <= divisor;
            quotient <= dividend;
            cnt      <= 6'(M2_W);
            busy     <= 1'b1;
         end else if (busy) begin
            // remainder after subtract is below den, so it fits S_W bits
            if (take)
               rem <= trial[S_W-1:0] - den;
            else
               rem <= trial[S_W-1:0];
            quotient <= {quotient[M2_W-2:0], take};
            cnt      <= cnt - 6'd1;
            if (cnt == 6'd1) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/my_project.sv
// Streaming moment estimator: peak, mean and variance of one crop,
// five single-word result streams, ap_ctrl_hs control.
module my_project
   import my_project_pkg::*;
(
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic [DATA_W-1:0] conv2d_input_V_data_0_V_TDATA,
   input  logic              conv2d_input_V_data_0_V_TVALID,
   output logic              conv2d_input_V_data_0_V_TREADY,
   output logic [DATA_W-1:0] layer15_out_V_data_0_V_TDATA,
   output logic              layer15_out_V_data_0_V_TVALID,
   input  logic              layer15_out_V_data_0_V_TREADY,
   output logic [DATA_W-1:0] layer15_out_V_data_1_V_TDATA,
   output logic              layer15_out_V_data_1_V_TVALID,
   input  logic              layer15_out_V_data_1_V_TREADY,
   output logic [DATA_W-1:0] layer15_out_V_data_2_V_TDATA,
   output logic              layer15_out_V_data_2_V_TVALID,
   input  logic              layer15_out_V_data_2_V_TREADY,
   output logic [DATA_W-1:0] layer15_out_V_data_3_V_TDATA,
   output logic              layer15_out_V_data_3_V_TVALID,
   input  logic              layer15_out_V_data_3_V_TREADY,
   output logic [DATA_W-1:0] layer15_out_V_data_4_V_TDATA,
   output logic              layer15_out_V_data_4_V_TVALID,
   input  logic              layer15_out_V_data_4_V_TREADY
);

   state_t                   state;
   logic [XY_W-1:0]          x;
   logic [XY_W-1:0]          y;
   logic signed [DATA_W-1:0] peak;
   logic [S_W-1:0]           s;
   logic [M1_W-1:0]          sx;
   logic [M1_W-1:0]          sy;
   logic [M2_W-1:0]          sxx;
   logic [M2_W-1:0]          syy;
   logic [DATA_W-1:0]        mx, my, qx, qy;
   logic [DATA_W-1:0]        res [NRES];
   logic [NRES-1:0]          ovalid;
   logic [NRES-1:0]          ordy;
   logic [NRES-1:0]          nvalid;
   logic [2:0]               step;
   logic                     waiting;
   logic                     in_ready;

   logic                     div_start;
   logic                     div_busy;
   logic                     div_done;
   logic [M2_W-1:0]          div_q;
   logic [M2_W-1:0]          dividend;

   logic signed [DATA_W-1:0] pix;
   logic [DATA_W-2:0]        w;
   logic                     beat;
   logic                     last;
   logic [M1_W-1:0]          xw, yw;
   logic [M2_W-1:0]          xxw, yyw;
   logic [31:0]              vx_d, vy_d;

   assign pix  = conv2d_input_V_data_0_V_TDATA;
   assign w    = pix[DATA_W-1] ? '0 : pix[DATA_W-2:0];
   assign beat = conv2d_input_V_data_0_V_TVALID && in_ready;
   assign last = (x == XY_W'(COLS-1)) && (y == XY_W'(ROWS-1));

   assign xw  = M1_W'(x) * M1_W'(w);
   assign yw  = M1_W'(y) * M1_W'(w);
   assign xxw = M2_W'(x) * M2_W'(x) * M2_W'(w);
   assign yyw = M2_W'(y) * M2_W'(y) * M2_W'(w);

   // second moment minus squared mean; sign bit flags clamp-to-zero
   assign vx_d = {16'b0, qx} - 32'(mx) * 32'(mx);
   assign vy_d = {16'b0, qy} - 32'(my) * 32'(my);

   always_comb begin
      dividend = syy;
      unique case (step)
         3'd0:    dividend = M2_W'(sx);
         3'd1:    dividend = M2_W'(sy);
         3'd2:    dividend = sxx;
         default: dividend = syy;
      endcase
   end

   assign ordy = {layer15_out_V_data_4_V_TREADY,
                  layer15_out_V_data_3_V_TREADY,
                  layer15_out_V_data_2_V_TREADY,
                  layer15_out_V_data_1_V_TREADY,
                  layer15_out_V_data_0_V_TREADY};
   assign nvalid = ovalid & ~ordy;

   my_project_div u_div (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (s),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state     <= IDLE;
         x         <= '0;
         y         <= '0;
         peak      <= '0;
         s         <= '0;
         sx        <= '0;
         sy        <= '0;
         sxx       <= '0;
         syy       <= '0;
         mx        <= '0;
         my        <= '0;
         qx        <= '0;
         qy        <= '0;
         res       <= '{default: '0};
         ovalid    <= '0;
         step      <= '0;
         waiting   <= 1'b0;
         in_ready  <= 1'b0;
         div_start <= 1'b0;
         ap_done   <= 1'b0;
         ap_ready  <= 1'b0;
         ap_idle   <= 1'b1;
      end else begin
         ap_done   <= 1'b0;
         ap_ready  <= 1'b0;
         div_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ap_start) begin
                  state    <= LOAD;
                  ap_idle  <= 1'b0;
                  in_ready <= 1'b1;
                  x        <= '0;
                  y        <= '0;
                  peak     <= 16'sh8000;
                  s        <= '0;
                  sx       <= '0;
                  sy       <= '0;
                  sxx      <= '0;
                  syy      <= '0;
               end
            end
            LOAD: begin
               if (beat) begin
                  if (pix > peak)
                     peak <= pix;
                  s   <= s + S_W'(w);
                  sx  <= sx + xw;
                  sy  <= sy + yw;
                  sxx <= sxx + xxw;
                  syy <= syy + yyw;
                  if (x == XY_W'(COLS-1)) begin
                     x <= '0;
                     y <= y + XY_W'(1);
                  end else begin
                     x <= x + XY_W'(1);
                  end
                  if (last) begin
                     state    <= CALC;
                     ap_ready <= 1'b1;
                     in_ready <= 1'b0;
                     step     <= '0;
                     waiting  <= 1'b0;
                  end
               end
            end
            CALC: begin
               if (step == 3'd4) begin
                  res[0] <= peak;
                  res[1] <= mx;
                  res[2] <= my;
                  res[3] <= vx_d[31] ? '0 : sat_u(M2_W'(vx_d[30:0]));
                  res[4] <= vy_d[31] ? '0 : sat_u(M2_W'(vy_d[30:0]));
                  ovalid <= '1;
                  state  <= OUT;
               end else if (s == '0) begin
                  mx   <= '0;
                  my   <= '0;
                  qx   <= '0;
                  qy   <= '0;
                  step <= 3'd4;
               end else if (!waiting && !div_busy) begin
                  div_start <= 1'b1;
                  waiting   <= 1'b1;
               end else if (div_done) begin
                  unique case (step)
                     3'd0:    mx <= sat_u(div_q);
                     3'd1:    my <= sat_u(div_q);
                     3'd2:    qx <= sat_u(div_q);
                     default: qy <= sat_u(div_q);
                  endcase
                  step <= step + 3'd1;
                  // chain the next division straight away
                  if (step != 3'd3)
                     div_start <= 1'b1;
                  else
                     waiting <= 1'b0;
               end
            end
            OUT: begin
               ovalid <= nvalid;
               if (nvalid == '0) begin
                  ap_done <= 1'b1;
                  ap_idle <= 1'b1;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end

   assign conv2d_input_V_data_0_V_TREADY = in_ready;

   assign layer15_out_V_data_0_V_TDATA  = res[0];
   assign layer15_out_V_data_1_V_TDATA  = res[1];
   assign layer15_out_V_data_2_V_TDATA  = res[2];
   assign layer15_out_V_data_3_V_TDATA  = res[3];
   assign layer15_out_V_data_4_V_TDATA  = res[4];
   assign layer15_out_V_data_0_V_TVALID = ovalid[0];
   assign layer15_out_V_data_1_V_TVALID = ovalid[1];
   assign layer15_out_V_data_2_V_TVALID = ovalid[2];
   assign layer15_out_V_data_3_V_TVALID = ovalid[3];
   assign layer15_out_V_data_4_V_TVALID = ovalid[4];

endmodule

// File: tb/tb_my_project.sv
// Bench for my_project: table of frames with expected results,
// per-channel scoreboard queues, reset-abort and held-start sequences.
module tb_my_project;
   import my_project_pkg::*;

   typedef struct {
      int              kind;
      bit              rv;
      bit              rr;
      logic [4:0][15:0] exp;
   } vec_t;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        ap_start;
   logic        ap_done, ap_idle, ap_ready;
   logic [15:0] id;
   logic        iv;
   logic        irdy;
   wire  [15:0] od [5];
   wire  [4:0]  ov;
   logic [4:0]  ordy;

   int tests = 0;
   int fails = 0;
   int done_cnt, ready_cnt;
   int beats [5];
   bit rr_mode;
   bit lat_on;
   int lat, lat_last;
   logic [15:0] sbq [5][$];
   logic [4:0]  pv, pr;
   logic [15:0] pd [5];
   vec_t tbl [4];

   always #5 ap_clk = ~ap_clk;

   my_project dut (
      .ap_clk                         (ap_clk),
      .ap_rst                         (ap_rst),
      .ap_start                       (ap_start),
      .ap_done                        (ap_done),
      .ap_idle                        (ap_idle),
      .ap_ready                       (ap_ready),
      .conv2d_input_V_data_0_V_TDATA  (id),
      .conv2d_input_V_data_0_V_TVALID (iv),
      .conv2d_input_V_data_0_V_TREADY (irdy),
      .layer15_out_V_data_0_V_TDATA   (od[0]),
      .layer15_out_V_data_0_V_TVALID  (ov[0]),
      .layer15_out_V_data_0_V_TREADY  (ordy[0]),
      .layer15_out_V_data_1_V_TDATA   (od[1]),
      .layer15_out_V_data_1_V_TVALID  (ov[1]),
      .layer15_out_V_data_1_V_TREADY  (ordy[1]),
      .layer15_out_V_data_2_V_TDATA   (od[2]),
      .layer15_out_V_data_2_V_TVALID  (ov[2]),
      .layer15_out_V_data_2_V_TREADY  (ordy[2]),
      .layer15_out_V_data_3_V_TDATA   (od[3]),
      .layer15_out_V_data_3_V_TVALID  (ov[3]),
      .layer15_out_V_data_3_V_TREADY  (ordy[3]),
      .layer15_out_V_data_4_V_TDATA   (od[4]),
      .layer15_out_V_data_4_V_TVALID  (ov[4]),
      .layer15_out_V_data_4_V_TREADY  (ordy[4])
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] pix(input int kind, input int idx);
      case (kind)
         0:       return 16'd1;
         1:       return (idx == 10*COLS + 20) ? 16'd100 : 16'd0;
         default: return 16'hFFFB;
      endcase
   endfunction

   function automatic vec_t mk(input int kind, input bit rv, input bit rr,
                               input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3,
                               input logic [15:0] e4);
      vec_t v;
      v.kind = kind;
      v.rv = rv;
      v.rr = rr;
      v.exp[0] = e0;
      v.exp[1] = e1;
      v.exp[2] = e2;
      v.exp[3] = e3;
      v.exp[4] = e4;
      return v;
   endfunction

   // sink side: set ready at negedge, sample the pending handshake 1ns later
   always @(negedge ap_clk) begin
      for (int k = 0; k < 5; k++)
         ordy[k] = rr_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (ap_ready) ready_cnt++;
      if (ap_done) done_cnt++;
      if (ap_ready) begin
         lat_on = 1'b1;
         lat = 0;
      end else if (lat_on) begin
         lat++;
         if (ov != 5'd0) begin
            lat_on = 1'b0;
            lat_last = lat;
         end
      end
      for (int k = 0; k < 5; k++) begin
         if (pv[k] && !pr[k])
            chk($sformatf("hold_ch%0d", k), {ov[k], od[k]}, {1'b1, pd[k]});
         if (ov[k] && ordy[k]) begin
            beats[k]++;
            if (sbq[k].size() == 0)
               chk($sformatf("unexpected_ch%0d", k), 1, 0);
            else
               chk($sformatf("data_ch%0d", k), od[k], sbq[k].pop_front());
         end
         pv[k] = ov[k];
         pr[k] = ordy[k];
         pd[k] = od[k];
      end
   end

   task automatic clr_counts();
      done_cnt = 0;
      ready_cnt = 0;
      for (int k = 0; k < 5; k++) beats[k] = 0;
   endtask

   task automatic push_exp(input vec_t v);
      for (int k = 0; k < 5; k++) sbq[k].push_back(v.exp[k]);
   endtask

   task automatic pulse_start();
      @(negedge ap_clk) ap_start = 1'b1;
      @(negedge ap_clk) ap_start = 1'b0;
   endtask

   task automatic drive(input int kind, input bit rv, input int nb);
      int idx = 0;
      int cyc = 0;
      while (idx < nb && cyc < 20000) begin
         @(negedge ap_clk);
         iv = rv ? 1'($urandom_range(0, 1)) : 1'b1;
         id = pix(kind, idx);
         #1;
         if (iv && irdy) idx++;
         cyc++;
      end
      @(negedge ap_clk) iv = 1'b0;
      if (idx < nb) chk("in_timeout", idx, nb);
   endtask

   task automatic wait_done(input int target, input int budget);
      int cyc = 0;
      while (done_cnt < target && cyc < budget) begin
         @(negedge ap_clk);
         cyc++;
      end
      repeat (3) @(negedge ap_clk);
      chk("done_count", done_cnt, target);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      rr_mode = v.rr;
      clr_counts();
      push_exp(v);
      pulse_start();
      drive(v.kind, v.rv, NPIX);
      wait_done(1, 2000);
      chk({nm, "_ap_ready"}, ready_cnt, 1);
      for (int k = 0; k < 5; k++)
         chk($sformatf("%s_beats_ch%0d", nm, k), beats[k], 1);
      chk({nm, "_idle"}, ap_idle, 1);
      chk({nm, "_calc_lat_ok"}, (lat_last > 0 && lat_last <= 170), 1);
      rr_mode = 1'b0;
   endtask

   initial begin
      ap_rst = 1'b1;
      ap_start = 1'b0;
      iv = 1'b0;
      id = '0;
      rr_mode = 1'b0;
      lat_on = 1'b0;
      lat = 0;
      lat_last = 0;
      pv = '0;
      pr = '0;
      clr_counts();

      tbl[0] = mk(0, 0, 0, 16'd1, 16'd23, 16'd23, 16'd215, 16'd215);
      tbl[1] = mk(1, 0, 0, 16'd100, 16'd20, 16'd10, 16'd0, 16'd0);
      tbl[2] = mk(2, 0, 0, 16'hFFFB, 16'd0, 16'd0, 16'd0, 16'd0);
      tbl[3] = mk(0, 1, 1, 16'd1, 16'd23, 16'd23, 16'd215, 16'd215);

      repeat (3) @(negedge ap_clk);
      chk("rst_idle", ap_idle, 1);
      chk("rst_tready", irdy, 0);
      chk("rst_tvalid", ov, 0);
      chk("rst_done_ready", {ap_done, ap_ready}, 0);
      ap_rst = 1'b0;
      repeat (2) @(negedge ap_clk);

      for (int t = 0; t < 4; t++)
         run_vec(tbl[t], $sformatf("T%0d", t + 1));

      // abort a frame with reset part way through loading
      clr_counts();
      pulse_start();
      drive(0, 0, 1000);
      chk("T5_loading", irdy, 1);
      @(negedge ap_clk) ap_rst = 1'b1;
      #2;
      chk("T5_rst_idle", ap_idle, 1);
      chk("T5_rst_tready", irdy, 0);
      @(negedge ap_clk) ap_rst = 1'b0;
      chk("T5_no_ready", ready_cnt, 0);
      run_vec(tbl[1], "T5");

      // start held high across two frames
      clr_counts();
      push_exp(tbl[0]);
      push_exp(tbl[1]);
      @(negedge ap_clk) ap_start = 1'b1;
      drive(0, 0, NPIX);
      drive(1, 0, NPIX);
      ap_start = 1'b0;
      wait_done(2, 2000);
      chk("T6_ap_ready", ready_cnt, 2);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("T6_beats_ch%0d", k), beats[k], 2);
         chk($sformatf("T6_sb_empty_ch%0d", k), sbq[k].size(), 0);
      end
      repeat (5) @(negedge ap_clk);
      chk("T6_idle", ap_idle, 1);
      chk("T6_no_restart", irdy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
